// File: rtl/div_iter.sv
// Multi-cycle unsigned restoring divider; retires BITS_PER_CYCLE quotient bits per clock
// and reports results with a one-cycle done pulse, using a start/busy/done handshake.
module div_iter #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int ITERS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = $clog2(ITERS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH:0]   rem_acc, rem_nxt;
  logic [WIDTH-1:0] q_sh, q_nxt, dvs;
  logic [CW-1:0]    count;
  logic             last_step;

  // Unrolled restoring steps; the trial subtract is a compare so no borrow bit is kept.
  always_comb begin
    rem_nxt = rem_acc;
    q_nxt   = q_sh;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      rem_nxt = {rem_nxt[WIDTH-1:0], q_nxt[WIDTH-1]};
      q_nxt   = q_nxt << 1;
      if (rem_nxt >= {1'b0, dvs}) begin
        rem_nxt  = rem_nxt - {1'b0, dvs};
        q_nxt[0] = 1'b1;
      end
    end
  end

  assign last_step = (count == CW'(ITERS - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      count       <= '0;
      rem_acc     <= '0;
      q_sh        <= '0;
      dvs         <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            rem_acc <= '0;
            q_sh    <= dividend;
            dvs     <= divisor;
            count   <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          rem_acc <= rem_nxt;
          q_sh    <= q_nxt;
          count   <= count + CW'(1);
          if (last_step) begin
            quotient    <= q_nxt;
            remainder   <= rem_nxt[WIDTH-1:0];
            div_by_zero <= (dvs == '0);
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: directed vector table, handshake corner cases, random operands,
// and a sweep of BITS_PER_CYCLE variants, all checked against a / and % reference.
module tb_div_iter;

  localparam int W     = 16;
  localparam int BPC   = 4;
  localparam int ITERS = W / BPC;
  localparam int NSW   = 4;
  localparam int SW_BPC [NSW] = '{1, 2, 8, 16};

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    res_t         exp;
  } vec_t;

  logic         clock = 1'b0;
  logic         reset, start, busy, done, dbz;
  logic [W-1:0] dividend, divisor, quotient, remainder;

  logic           sw_start;
  logic [W-1:0]   sw_a, sw_b;
  logic [NSW-1:0] sw_busy, sw_done, sw_dbz;
  logic [W-1:0]   sw_q [NSW];
  logic [W-1:0]   sw_r [NSW];

  int   checks = 0;
  int   errors = 0;
  int   n_done = 0;
  int   sw_cnt [NSW];
  res_t sb [$];
  res_t last, mon_e, sw_exp;
  vec_t tbl [10];
  vec_t ops [6];

  always #5 clock = ~clock;

  div_iter #(.WIDTH(W), .BITS_PER_CYCLE(BPC)) u_dut (
    .clock(clock), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(dbz)
  );

  generate
    for (genvar g = 0; g < NSW; g++) begin : g_sw
      div_iter #(.WIDTH(W), .BITS_PER_CYCLE(SW_BPC[g])) u_sw (
        .clock(clock), .reset(reset), .start(sw_start), .dividend(sw_a), .divisor(sw_b),
        .busy(sw_busy[g]), .done(sw_done[g]), .quotient(sw_q[g]), .remainder(sw_r[g]),
        .div_by_zero(sw_dbz[g])
      );
    end
  endgenerate

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t m;
    if (b == '0) m = '{q: '1, r: a, dbz: 1'b1};
    else         m = '{q: a / b, r: a % b, dbz: 1'b0};
    return m;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return W'(0);
      1:       return W'(1);
      2:       return '1;
      3:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  // Scoreboard: each done pops the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && done === 1'b1) begin
      n_done++;
      chk("sb_nonempty_at_done", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("quotient", quotient, mon_e.q);
        chk("remainder", remainder, mon_e.r);
        chk("div_by_zero", dbz, mon_e.dbz);
        last = mon_e;
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      for (int g = 0; g < NSW; g++) begin
        if (sw_done[g]) begin
          sw_cnt[g]++;
          chk($sformatf("sweep%0d_q", SW_BPC[g]), sw_q[g], sw_exp.q);
          chk($sformatf("sweep%0d_r", SW_BPC[g]), sw_r[g], sw_exp.r);
          chk($sformatf("sweep%0d_dbz", SW_BPC[g]), sw_dbz[g], sw_exp.dbz);
        end
      end
    end
  end

  // Called and returns 1 time unit after a rising edge.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input res_t exp);
    start = 1'b1; dividend = a; divisor = b;
    sb.push_back(exp);
    @(posedge clock); #1;
    start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    for (int c = 0; c < ITERS; c++) begin
      chk("busy_during_run", busy, 1);
      chk("done_early", done, 0);
      chk("quotient_stable", quotient, last.q);
      chk("remainder_stable", remainder, last.r);
      @(posedge clock); #1;
    end
    chk("done_at_latency", done, 1);
    chk("busy_at_done", busy, 0);
    @(posedge clock); #1;
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd0;
    tbl[0] = '{16'd100,   16'd7,     '{16'd14,   16'd2,    1'b0}};
    tbl[1] = '{16'hFFFF,  16'h0001,  '{16'hFFFF, 16'h0000, 1'b0}};
    tbl[2] = '{16'd5,     16'd9,     '{16'd0,    16'd5,    1'b0}};
    tbl[3] = '{16'h1234,  16'h0000,  '{16'hFFFF, 16'h1234, 1'b1}};
    tbl[4] = '{16'd0,     16'd5,     '{16'd0,    16'd0,    1'b0}};
    tbl[5] = '{16'hFFFF,  16'hFFFF,  '{16'd1,    16'd0,    1'b0}};
    tbl[6] = '{16'd1,     16'hFFFF,  '{16'd0,    16'd1,    1'b0}};
    tbl[7] = '{16'd0,     16'd0,     '{16'hFFFF, 16'd0,    1'b1}};
    tbl[8] = '{16'hFFFF,  16'd0,     '{16'hFFFF, 16'hFFFF, 1'b1}};
    tbl[9] = '{16'd65535, 16'd256,   '{16'd255,  16'd255,  1'b0}};

    ops[0] = '{16'd60000, 16'd7,   '{16'd8571, 16'd3,   1'b0}};
    ops[1] = '{16'd9,     16'd3,   '{16'd3,    16'd0,   1'b0}};
    ops[2] = '{16'd1000,  16'd3,   '{16'd333,  16'd1,   1'b0}};
    ops[3] = '{16'h4321,  16'd0,   '{16'hFFFF, 16'h4321, 1'b1}};
    ops[4] = '{16'd1,     16'd1,   '{16'd1,    16'd0,   1'b0}};
    ops[5] = '{16'd777,   16'd5,   '{16'd155,  16'd2,   1'b0}};

    for (int g = 0; g < NSW; g++) sw_cnt[g] = 0;
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    sw_start = 1'b0; sw_a = '0; sw_b = '0; last = '0; sw_exp = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_dbz", dbz, 0);
    chk("reset_sweep_busy", sw_busy, 0);

    foreach (tbl[i]) run_div(tbl[i].a, tbl[i].b, tbl[i].exp);

    // Start pulsed during RUN is dropped.
    nd0 = n_done;
    start = 1'b1; dividend = 16'd1000; divisor = 16'd10;
    sb.push_back('{16'd100, 16'd0, 1'b0});
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    start = 1'b1; dividend = 16'd50; divisor = 16'd5;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clock); #1; end
    chk("ignored_start_done_count", n_done - nd0, 1);
    chk("ignored_start_sb_empty", sb.size(), 0);

    // Start held high: a new divide is accepted in every done cycle.
    start = 1'b1; dividend = ops[0].a; divisor = ops[0].b;
    sb.push_back(ops[0].exp);
    @(posedge clock); #1;
    foreach (ops[n]) begin
      for (int c = 0; c < ITERS; c++) begin
        chk("b2b_busy", busy, 1);
        chk("b2b_done_early", done, 0);
        chk("b2b_quotient_stable", quotient, last.q);
        @(posedge clock); #1;
      end
      chk("b2b_done", done, 1);
      chk("b2b_busy_at_done", busy, 0);
      if (n < 5) begin
        dividend = ops[n+1].a; divisor = ops[n+1].b;
        sb.push_back(ops[n+1].exp);
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
    end
    chk("b2b_sb_empty", sb.size(), 0);

    // Reset two cycles into a divide aborts it silently.
    nd0 = n_done;
    start = 1'b1; dividend = 16'd500; divisor = 16'd3;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_dbz", dbz, 0);
    last = '0;
    repeat (8) begin @(posedge clock); #1; end
    chk("abort_no_done", n_done - nd0, 0);
    run_div(16'd81, 16'd9, '{16'd9, 16'd0, 1'b0});

    for (int i = 0; i < 2000; i++) begin
      logic [W-1:0] a, b;
      a = pick(); b = pick();
      run_div(a, b, model(a, b));
    end
    chk("main_sb_empty", sb.size(), 0);

    for (int i = 0; i < 1500; i++) begin
      sw_a = pick(); sw_b = pick();
      sw_exp = model(sw_a, sw_b);
      sw_start = 1'b1;
      @(posedge clock); #1;
      sw_start = 1'b0;
      for (int c = 0; c < 40 && sw_busy != '0; c++) begin
        @(posedge clock); #1;
      end
      chk("sweep_timeout", sw_busy, 0);
      @(posedge clock); #1;
    end
    for (int g = 0; g < NSW; g++)
      chk($sformatf("sweep%0d_done_count", SW_BPC[g]), sw_cnt[g], 1500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
